// File: rtl/sigmoid_approx_fn.sv
// sigmoid_approx_fn
// Signed Q4.12 sigmoid using a four-segment shift-and-add piecewise-linear
// approximation. One sample per enabled clock, one cycle of latency.
// The result lies in [0x0000, 0x1000], where 0x1000 represents 1.0.

module sigmoid_approx_fn (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        ENABLE,
    input  logic [15:0] in,
    output logic [15:0] out,
    output logic        out_valid
);

    // Positive-half approximation p(a) on the magnitude a = |x|.
    // Right shifts truncate. The result never exceeds 0x1000.
    function automatic logic [16:0] pos_half(input logic [16:0] a);
        logic [16:0] p;
        if (a < 17'h01000) begin
            p = (a >> 2) + 17'h00800;
        end else if (a < 17'h02600) begin
            p = (a >> 3) + 17'h00A00;
        end else if (a < 17'h05000) begin
            p = (a >> 5) + 17'h00D80;
        end else begin
            p = 17'h01000;
        end
        return p;
    endfunction

    logic [16:0] mag_s;
    logic [16:0] pos_s;
    logic [16:0] res_s;
    logic [15:0] out_d;
    logic [15:0] out_q;
    logic        out_valid_q;

    // Magnitude, positive-half value and sign fold, computed in 17 bits.
    // Negating 0x8000 in 17 bits yields 0x8000 without overflow.
    always_comb begin
        mag_s = 17'h00000;
        pos_s = 17'h00000;
        res_s = 17'h00000;
        if (in[15]) begin
            mag_s = 17'h10000 - {1'b0, in};
        end else begin
            mag_s = {1'b0, in};
        end
        pos_s = pos_half(mag_s);
        if (in[15]) begin
            res_s = 17'h01000 - pos_s;
        end else begin
            res_s = pos_s;
        end
        out_d = res_s[15:0];
    end

    // Output register: reset clears the result, ENABLE loads a new one,
    // otherwise the last result is held and valid drops.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            out_q       <= 16'h0000;
            out_valid_q <= 1'b0;
        end else if (ENABLE) begin
            out_q       <= out_d;
            out_valid_q <= 1'b1;
        end else begin
            out_q       <= out_q;
            out_valid_q <= 1'b0;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_sigmoid_approx_fn.sv
// Self-checking bench for sigmoid_approx_fn: directed steps, random symmetry
// pairs and an exhaustive sweep compared against an integer reference model.

module tb_sigmoid_approx_fn;

    logic        CLK;
    logic        RESET_N;
    logic        ENABLE;
    logic [15:0] in;
    logic [15:0] out;
    logic        out_valid;

    int checks;
    int errors;

    sigmoid_approx_fn dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .ENABLE   (ENABLE),
        .in       (in),
        .out      (out),
        .out_valid(out_valid)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference: sigmoid approximation from the piecewise rules, plain integers.
    function automatic int ref_sig(input logic [15:0] v);
        int x;
        int a;
        int p;
        x = int'($signed(v));
        a = (x < 0) ? -x : x;
        if (a < 4096)       p = a / 4 + 2048;
        else if (a < 9728)  p = a / 8 + 2560;
        else if (a < 20480) p = a / 32 + 3456;
        else                p = 4096;
        return (x < 0) ? (4096 - p) : p;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic feed_check(input string tag, input logic [15:0] v, input int exp);
        in = v;
        ENABLE = 1'b1;
        tick();
        check({tag, "_out"}, int'(out), exp);
        check({tag, "_vld"}, int'(out_valid), 1);
    endtask

    initial begin
        int o1;
        int o2;
        int x;
        logic [15:0] v;
        checks  = 0;
        errors  = 0;
        RESET_N = 1'b0;
        ENABLE  = 1'b1;
        in      = 16'h0700;

        // 1. Reset with ENABLE high, then release.
        tick();
        tick();
        check("rst_out", int'(out), 0);
        check("rst_vld", int'(out_valid), 0);
        RESET_N = 1'b1;
        tick();
        check("rel_out", int'(out), 32'h09C0);
        check("rel_vld", int'(out_valid), 1);

        // 2. Segment 1, back to back.
        feed_check("s1_0700", 16'h0700, 32'h09C0);
        feed_check("s1_0230", 16'h0230, 32'h088C);
        feed_check("s1_0822", 16'h0822, 32'h0A08);
        feed_check("s1_0315", 16'h0315, 32'h08C5);
        feed_check("s1_0000", 16'h0000, 32'h0800);

        // 3. Segments 2 and 3 (0x2600: 0x130 + 0xD80).
        feed_check("s2_1420", 16'h1420, 32'h0C84);
        feed_check("s2_1997", 16'h1997, 32'h0D32);
        feed_check("s3_3000", 16'h3000, 32'h0F00);
        feed_check("s3_2600", 16'h2600, 32'h0EB0);
        feed_check("s2_1000", 16'h1000, 32'h0C00);
        feed_check("s1_0fff", 16'h0FFF, 32'h0BFF);

        // 4. Saturation and extremes.
        feed_check("sat_7fff", 16'h7FFF, 32'h1000);
        feed_check("sat_5000", 16'h5000, 32'h1000);
        feed_check("s3_4fff", 16'h4FFF, 32'h0FFF);
        feed_check("neg_8000", 16'h8000, 32'h0000);
        feed_check("neg_b000", 16'hB000, 32'h0000);

        // 5. Negative symmetry.
        feed_check("neg_f900", 16'hF900, 32'h0640);
        feed_check("neg_d000", 16'hD000, 32'h0100);
        for (int i = 0; i < 200; i++) begin
            x = int'($urandom_range(0, 32'h7FFF));
            v = 16'(x);
            feed_check("rnd_pos", v, ref_sig(v));
            o1 = int'(out);
            v = 16'(-x);
            feed_check("rnd_neg", v, ref_sig(v));
            o2 = int'(out);
            check("sym_sum", o1 + o2, 32'h1000);
        end

        // 6. ENABLE gating: hold value, valid low, while input changes.
        feed_check("gate_0700", 16'h0700, 32'h09C0);
        ENABLE = 1'b0;
        in = 16'h1420;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("gate_hold_out", int'(out), 32'h09C0);
            check("gate_hold_vld", int'(out_valid), 0);
        end
        ENABLE = 1'b1;
        tick();
        check("gate_resume_out", int'(out), 32'h0C84);
        check("gate_resume_vld", int'(out_valid), 1);

        // Reset mid-stream discards pending result, first result after release.
        in = 16'h3000;
        RESET_N = 1'b0;
        tick();
        check("mid_rst_out", int'(out), 0);
        check("mid_rst_vld", int'(out_valid), 0);
        RESET_N = 1'b1;
        in = 16'h0315;
        tick();
        check("post_rst_out", int'(out), 32'h08C5);
        check("post_rst_vld", int'(out_valid), 1);

        // Exhaustive sweep of all inputs.
        for (int i = 0; i < 65536; i++) begin
            v = 16'(i);
            in = v;
            ENABLE = 1'b1;
            tick();
            checks++;
            assert (int'(out) === ref_sig(v) && out_valid === 1'b1) else begin
                errors++;
                $error("FAIL sweep in=%h observed=%h/%b expected=%h/1", v, out, out_valid, ref_sig(v));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
